// File: rtl/pwm_decode.sv
// pwm_decode: recovers the brightness code from a 2^WIDTH-clock PWM waveform, with a timeout for constant inputs
module pwm_decode #(
  parameter int WIDTH   = 8,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 2 * (2 ** WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] bright,
  output logic             valid,
  output logic             locked,
  output logic             err
);
  localparam int CW     = WIDTH + 2;
  localparam int PERIOD = 2 ** WIDTH;
  localparam logic [CW-1:0] P_LO  = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] P_HI  = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] T_OUT = CW'(TIMEOUT);
  localparam logic [CW-1:0] B_MAX = CW'(PERIOD - 1);
  typedef enum logic {HUNT, TRACK} state_t;
  state_t state, state_nx;
  logic meta, s, s_d, rise, in_tol;
  logic [CW-1:0] period_cnt, high_cnt, period_nx, high_nx;
  logic [WIDTH-1:0] bright_nx;
  logic valid_nx, err_nx, locked_nx;
  assign rise   = s & ~s_d;
  assign in_tol = period_cnt >= P_LO && period_cnt <= P_HI;
  always_comb begin
    state_nx  = state;
    bright_nx = bright;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    locked_nx = locked;
    period_nx = &period_cnt ? period_cnt : period_cnt + CW'(1);
    high_nx   = &high_cnt ? high_cnt : high_cnt + CW'(s);
    if (rise) begin
      period_nx = CW'(1);
      high_nx   = CW'(1);
      state_nx  = TRACK;
      if (state == TRACK) begin
        bright_nx = in_tol ? (high_cnt > B_MAX ? '1 : high_cnt[WIDTH-1:0]) : bright;
        valid_nx  = in_tol;
        err_nx    = ~in_tol;
        locked_nx = in_tol;
      end
    end else if (period_cnt == T_OUT) begin
      // constant input: report 0% or 100% and re-arm for the next timeout
      bright_nx = {WIDTH{s}};
      valid_nx  = 1'b1;
      locked_nx = 1'b0;
      state_nx  = HUNT;
      period_nx = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {meta, s, s_d} <= '0;
      period_cnt     <= '0;
      high_cnt       <= '0;
      state          <= HUNT;
      bright         <= '0;
      valid          <= 1'b0;
      err            <= 1'b0;
      locked         <= 1'b0;
    end else begin
      meta       <= pwm_in;
      s          <= meta;
      s_d        <= s;
      period_cnt <= period_nx;
      high_cnt   <= high_nx;
      state      <= state_nx;
      bright     <= bright_nx;
      valid      <= valid_nx;
      err        <= err_nx;
      locked     <= locked_nx;
    end
  end
endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode: scoreboard bench for pwm_decode; expected events are queued as the waveform is driven
module tb_pwm_decode;
  localparam int TIMEOUT = 512;
  typedef struct {
    logic       e;
    logic [7:0] b;
    logic       l;
    int         lo;
    int         hi;
  } ev_t;
  logic clk = 1'b0;
  logic reset_n, pwm_in;
  logic [7:0] bright;
  logic valid, locked, err;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  ev_t x;
  logic have_ref = 1'b0;
  logic [7:0] last_bright = 8'd0;
  int prev_p, prev_h, last_rise;
  pwm_decode dut (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
    .bright(bright), .valid(valid), .locked(locked), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (valid || err)) begin
      check("excl", valid & err, 0);
      if (q.size() == 0) check("spurious", 1, 0);
      else begin
        x = q.pop_front();
        check("kind", err, x.e);
        check("bright", bright, x.b);
        check("locked", locked, x.l);
        check("when", cyc >= x.lo && cyc <= x.hi, 1);
      end
    end
  end
  task automatic meas();
    logic [7:0] b;
    b = (prev_h > 255) ? 8'd255 : 8'(prev_h);
    if (prev_p >= 254 && prev_p <= 258) begin
      q.push_back('{1'b0, b, 1'b1, cyc + 3, cyc + 3});
      last_bright = b;
    end else q.push_back('{1'b1, last_bright, 1'b0, cyc + 3, cyc + 3});
  endtask
  task automatic pulse(int p, int h, int rst_at = -1);
    if (have_ref) meas();
    have_ref  = 1'b1;
    prev_p    = p;
    prev_h    = h;
    last_rise = cyc;
    for (int i = 0; i < p; i++) begin
      pwm_in  = (i < h);
      reset_n = (i != rst_at);
      @(posedge clk); #1;
      if (i == rst_at) begin
        check("rst_bright", bright, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        have_ref    = 1'b0;
        last_bright = 8'd0;
      end
    end
    reset_n = 1'b1;
  endtask
  task automatic hold(logic lvl, int n_to);
    int r;
    if (lvl) begin
      if (have_ref) meas();
      last_rise = cyc;
    end
    r = last_rise;
    pwm_in = lvl;
    for (int k = 0; k < n_to; k++)
      q.push_back('{1'b0, {8{lvl}}, 1'b0, r + 3 + TIMEOUT + k * TIMEOUT, r + 3 + TIMEOUT + k * (TIMEOUT + 1)});
    last_bright = {8{lvl}};
    have_ref    = 1'b0;
    while (cyc < r + 1400) begin
      @(posedge clk); #1;
    end
    if (lvl) begin
      pwm_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end
  endtask
  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_bright", bright, 0);
    check("init_valid", valid, 0);
    check("init_locked", locked, 0);
    check("init_err", err, 0);
    reset_n = 1'b1;
    repeat (4) pulse(256, 64);
    pulse(256, 1);
    pulse(256, 128);
    pulse(256, 255);
    pulse(256, 64);
    pulse(258, 100);
    pulse(300, 50);
    pulse(256, 30);
    pulse(256, 40);
    pulse(257, 256);
    pulse(256, 64);
    hold(1'b0, 2);
    pulse(256, 64);
    pulse(256, 64);
    hold(1'b1, 2);
    pulse(256, 64);
    pulse(256, 64);
    pulse(256, 64, 150);
    pulse(256, 64);
    pulse(256, 77);
    pulse(256, 64);
    repeat (20) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
